// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner: counter prescaler, per-digit slots, PWM dimming,
// leading-zero blanking and frame-synchronous shadow update with acknowledge.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    update,
  output logic                    update_ack,
  input  logic                    lz_en,
  input  logic [3:0]              brightness,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned PRE_W  = $clog2(REFRESH_DIV);
  localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [3:0]              pwm_q, pwm_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] shd_dig_q, shd_dig_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;
  logic                    ack_q, ack_d;

  logic                    tick;
  logic                    wrap;
  logic [NUM_DIGITS-1:0]   blanked;
  logic                    all_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    lit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan timing: prescaler, slot index and PWM phase all freeze while disabled.
  always_comb begin
    tick    = enable && (presc_q == PRE_LAST);
    wrap    = tick && (slot_q == SLOT_LAST);
    presc_d = presc_q;
    slot_d  = slot_q;
    pwm_d   = pwm_q;
    if (enable) begin
      pwm_d   = pwm_q + 4'd1;
      presc_d = tick ? '0 : presc_q + PRE_W'(1);
      if (tick) begin
        slot_d = wrap ? '0 : slot_q + SLOT_W'(1);
      end
    end
  end

  // A strobe coinciding with the wrap bypasses the pending register so it lands this frame.
  always_comb begin
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_flag_d  = pend_flag_q;
    shd_dig_d    = shd_dig_q;
    shd_dp_d     = shd_dp_q;
    ack_d        = 1'b0;
    frame_done_d = wrap;
    if (update) begin
      pend_dig_d  = digits;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
    if (wrap) begin
      pend_flag_d = 1'b0;
      if (update) begin
        shd_dig_d = digits;
        shd_dp_d  = dp_in;
        ack_d     = 1'b1;
      end else if (pend_flag_q) begin
        shd_dig_d = pend_dig_q;
        shd_dp_d  = pend_dp_q;
        ack_d     = 1'b1;
      end
    end
  end

  always_comb begin
    blanked  = '0;
    all_zero = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      all_zero = all_zero && (shd_dig_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      blanked[NUM_DIGITS-1-k] = all_zero;
    end
    blanked[0] = 1'b0;
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (SLOT_W'(i) == slot_q) begin
        cur_nib   = shd_dig_q[4*i +: 4];
        cur_dp    = shd_dp_q[i];
        cur_blank = blanked[i];
      end
    end
  end

  always_comb begin
    lit   = enable && (pwm_q <= brightness) && !(lz_en && cur_blank);
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (lit) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (SLOT_W'(i) == slot_q) begin
          an_d[i] = 1'b0;
        end
      end
      seg_d = hex_to_seg(cur_nib);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      slot_q       <= '0;
      pwm_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      shd_dig_q    <= '0;
      shd_dp_q     <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      pwm_q        <= pwm_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      shd_dig_q    <= shd_dig_d;
      shd_dp_q     <= shd_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
      ack_q        <= ack_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;
  assign update_ack = ack_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: expected lit runs (anode, segments, dp, length)
// and expected acknowledges are queued by the stimulus and consumed by an output monitor.
module tb_seven_seg_scanner;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp_in = '0;
  logic        update = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic        enable = 1'b1;
  logic        update_ack;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .dp_in      (dp_in),
    .update     (update),
    .update_ack (update_ack),
    .lz_en      (lz_en),
    .brightness (brightness),
    .enable     (enable),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
  } run_t;

  run_t exp_runs[$];
  int   exp_acks[$];
  int   errors = 0;
  int   checks = 0;
  int   fd_count = 0;
  int   run_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_run(input logic [3:0] a, input logic [6:0] s, input logic d, input int len);
    run_t r;
    r.an  = a;
    r.seg = s;
    r.dp  = d;
    r.len = len;
    exp_runs.push_back(r);
  endtask

  // s0..s3 are digit 0..3 segment codes; dpn holds the active-low dp pin per digit.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpn, input int len);
    push_run(4'b1110, s0, dpn[0], len);
    push_run(4'b1101, s1, dpn[1], len);
    push_run(4'b1011, s2, dpn[2], len);
    push_run(4'b0111, s3, dpn[3], len);
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Output monitor: folds samples into runs and scores each finished lit run.
  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;
  int         r_len = 0;
  run_t       e;

  always @(negedge clk) begin
    check("one_anode_max", 32'($countones(~an) <= 1), 1);
    if (an === 4'hF) check("dark_seg_dp", {seg, dp}, {7'h7F, 1'b1});
    if (r_len > 0 && {an, seg, dp} !== {r_an, r_seg, r_dp}) begin
      if (r_an !== 4'hF) begin
        if (exp_runs.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_run: got an=%b seg=%h dp=%b len=%0d, expected none", r_an, r_seg, r_dp, r_len);
        end else begin
          e = exp_runs.pop_front();
          check($sformatf("run%0d_an", run_idx), r_an, e.an);
          check($sformatf("run%0d_seg", run_idx), r_seg, e.seg);
          check($sformatf("run%0d_dp", run_idx), r_dp, e.dp);
          check($sformatf("run%0d_len", run_idx), r_len, e.len);
        end
        run_idx++;
      end
      r_len = 0;
    end
    if (r_len == 0) begin
      r_an  = an;
      r_seg = seg;
      r_dp  = dp;
    end
    r_len++;
    if (frame_done === 1'b1) fd_count++;
    if (update_ack === 1'b1) begin
      check("ack_with_frame_done", frame_done, 1);
      if (exp_acks.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got update_ack=1 at frame %0d, expected no ack", fd_count);
      end else begin
        check("ack_frame", fd_count, exp_acks.pop_front());
      end
    end
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: got no completion by t=%0t, expected finish", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_frame_done", frame_done, 0);
    check("rst_ack", update_ack, 0);

    // Frame 0 shows the cleared shadow (all zeros, no suppression).
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, 16);
    reset = 1'b0;

    goto(10);
    digits = 16'h1234; update = 1'b1;
    exp_acks.push_back(1);
    goto(11);
    update = 1'b0;
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b1111, 16);

    // Mid-frame update must not tear frame 1.
    goto(80);
    digits = 16'hABCD; update = 1'b1;
    exp_acks.push_back(2);
    push_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'b1111, 16);
    goto(81);
    update = 1'b0;

    goto(130);
    lz_en = 1'b1;

    goto(140);
    digits = 16'h0050; update = 1'b1;
    exp_acks.push_back(3);
    push_run(4'b1110, 7'h40, 1'b1, 16);
    push_run(4'b1101, 7'h12, 1'b1, 16);
    goto(141);
    update = 1'b0;

    goto(200);
    digits = 16'h0000; update = 1'b1;
    exp_acks.push_back(4);
    push_run(4'b1110, 7'h40, 1'b1, 16);
    goto(201);
    update = 1'b0;

    // Strobe in the wrap cycle itself (wrap edge is 320).
    goto(319);
    digits = 16'h9999; dp_in = 4'b0100; update = 1'b1;
    exp_acks.push_back(5);
    push_frame(7'h10, 7'h10, 7'h10, 7'h10, 4'b1011, 16);
    goto(320);
    update = 1'b0;

    goto(384);
    brightness = 4'd3;
    push_frame(7'h10, 7'h10, 7'h10, 7'h10, 4'b1011, 4);

    goto(448);
    brightness = 4'd0;
    push_frame(7'h10, 7'h10, 7'h10, 7'h10, 4'b1011, 1);

    goto(512);
    brightness = 4'd15;
    push_run(4'b1110, 7'h10, 1'b1, 16);
    push_run(4'b1101, 7'h10, 1'b1, 16);
    push_run(4'b1011, 7'h10, 1'b0, 10);

    // Asynchronous reset between edges, ten cycles into digit 2's slot.
    goto(554);
    #6;
    reset = 1'b1;
    #1;
    check("midrst_an", an, 4'hF);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_dp", dp, 1);
    check("midrst_ack", update_ack, 0);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, 16);
    lz_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    goto(64);
    enable = 1'b0;
    goto(66);
    check("dis_an", an, 4'hF);
    check("dis_seg", seg, 7'h7F);
    check("dis_dp", dp, 1);

    goto(80);
    check("runs_left", exp_runs.size(), 0);
    check("acks_left", exp_acks.size(), 0);
    check("frame_done_count", fd_count, 9);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised multiplexed seven-segment display driver, successor to the fixed 4-digit quad display path. Scans NUM_DIGITS hex digits with a counter-based refresh prescaler in place of a divider chain. Adds decimal points, leading-zero suppression, PWM brightness, and tear-free frame-synchronous update with handshake. Sits between system-level value sources (switches, counters) and the board's seg/dp/an pins.

Parameters:
NUM_DIGITS, 4, digits scanned (legal 1..8)
REFRESH_DIV, 100000, clk cycles per digit slot (legal >= 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
digits  input  4*NUM_DIGITS  hex values; digit i = digits[4i+3:4i], digit 0 rightmost
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit
update  input  1  one-cycle strobe: capture digits/dp_in for display
update_ack  output  1  one-cycle pulse when captured value becomes visible
lz_en  input  1  leading-zero suppression enable
brightness  input  4  duty level 0..15
enable  input  1  display enable
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
an  output  NUM_DIGITS  digit anodes, active-low, an[0] = digit 0
frame_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (async, immediate): prescaler=0, slot=0, pwm=0, pending/shadow regs=0, pending_flag=0; an=all 1, seg=7'h7F, dp=1, frame_done=0, update_ack=0.
- Prescaler counts 0..REFRESH_DIV-1 while enable=1; at terminal count, slot increments; slot NUM_DIGITS-1 wraps to 0 ("wrap"), and frame_done pulses in the same cycle the slot register returns to 0.
- enable=0: prescaler, slot, pwm hold; an=all 1, seg=7'h7F, dp=1 next cycle. Update capture still works.
- update=1: digits/dp_in captured into pending; pending_flag set. Repeated updates before wrap: last write wins.
- At wrap: if update=1 that cycle, shadow <= live digits/dp_in directly; else if pending_flag, shadow <= pending. Either case: pending_flag cleared, update_ack pulses with frame_done. No load -> no ack.
- Display value changes only at frame boundaries; no mid-frame tearing.
- pwm: 4-bit free-running counter, increments every enabled cycle. Slot anode active only when pwm <= brightness; brightness=15 always on, brightness=0 is 1/16 duty.
- Leading-zero suppression (lz_en=1): digit i, i>0, is blanked if shadow digits NUM_DIGITS-1..i are all 0. Digit 0 is never blanked. Blanked digit: anode inactive, but the slot is still consumed.
- Decode, active-low hex 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Inactive anode cycle: seg=7'h7F, dp=1.
- an/seg/dp are registered: one clk latency from slot/pwm state to pins; exactly one anode is low at most.
- NUM_DIGITS=1: every slot terminal count is a wrap.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4, brightness=15: reset, update with digits=16'h1234 -> ack at first wrap; then an=1110/1101/1011/0111, 4 cycles each, seg=19/30/24/79.
- Mid-frame update 16'hABCD after 16'h1234 is visible -> rest of frame still shows 1234; at wrap update_ack=1 and next frame shows seg 21/46/03/08.
- lz_en=1, digits=16'h0050 -> digits 3,2 anodes stay high during their slots; digit1 seg=12, digit0 seg=40. digits=16'h0000 -> only digit0 lit with 40.
- REFRESH_DIV=16, brightness=3 -> in each 16-cycle slot, anode low for exactly 4 cycles (pwm 0..3); brightness=0 -> 1 cycle.
- update asserted in the same cycle as the wrap, with 16'h9999 -> next frame shows 9999, single update_ack; dp_in=4'b0100 -> dp=0 only during digit 2 slot.
- Assert reset mid-slot between clock edges -> an=all 1, seg=7'h7F immediately; after release, scan restarts at slot 0 with shadow=0.
